// File: rtl/seven_seg_scan4_if.sv
// Bundle between a BCD counter cascade and the multiplexed 4-digit display driver.
interface seven_seg_scan4_if;
   logic        en;
   logic [15:0] digits;
   logic [3:0]  dp_in;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;

   modport master (
      output en, digits, dp_in,
      input  seg, dp, an, frame_tick
   );

   modport slave (
      input  en, digits, dp_in,
      output seg, dp, an, frame_tick
   );
endinterface

// File: rtl/seven_seg_scan4.sv
// Four-digit multiplexed seven-segment driver with frame-latched digits,
// leading-zero blanking, dash for non-BCD codes and a dead cycle at each slot change.
module seven_seg_scan4 #(
   parameter int REFRESH_DIV    = 100000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1,
   parameter int BLANK_LEADING  = 1
) (
   input  logic             clk,
   input  logic             rst,
   seven_seg_scan4_if.slave bus
);
   localparam int          PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(REFRESH_DIV - 1);
   localparam logic [6:0]  SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic        DP_XOR  = (SEG_ACTIVE_LOW != 0);
   localparam logic [3:0]  AN_OFF  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

   function automatic logic [6:0] decode7(input logic [3:0] v);
      case (v)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   logic [PW-1:0]   pcnt_reg;
   logic [1:0]      slot_reg;
   logic [15:0]     shadow_reg;
   logic [3:0]      shadow_dp_reg;
   logic            en_reg;
   logic [6:0]      seg_reg;
   logic            dp_reg;
   logic [3:0]      an_reg;
   logic            frame_tick_reg;

   logic            slot_end;
   logic            frame_end;
   logic [3:0][6:0] pat;
   logic [3:0]      blank;
   logic [3:0]      an_sel;

   assign slot_end  = (pcnt_reg == PLAST);
   assign frame_end = slot_end && (slot_reg == 2'd3);
   assign an_sel    = 4'b0001 << slot_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         assign pat[gi] = decode7(shadow_reg[4*gi +: 4]);
      end
   endgenerate

   // A digit blanks only while every digit above it is also zero; its own dp keeps it lit.
   always_comb begin
      logic zeros_above;
      zeros_above = 1'b1;
      blank       = 4'b0000;
      for (int k = 3; k >= 1; k--) begin
         zeros_above = zeros_above && (shadow_reg[4*k +: 4] == 4'd0);
         blank[k]    = (BLANK_LEADING != 0) && zeros_above && !shadow_dp_reg[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_reg       <= '0;
         slot_reg       <= 2'd0;
         shadow_reg     <= 16'h0000;
         shadow_dp_reg  <= 4'h0;
         en_reg         <= 1'b0;
         seg_reg        <= SEG_XOR;
         dp_reg         <= DP_XOR;
         an_reg         <= AN_OFF;
         frame_tick_reg <= 1'b0;
      end else begin
         pcnt_reg <= slot_end ? '0 : pcnt_reg + PW'(1);
         if (slot_end) begin
            slot_reg <= slot_reg + 2'd1;
         end
         if (frame_end) begin
            shadow_reg    <= bus.digits;
            shadow_dp_reg <= bus.dp_in;
         end
         frame_tick_reg <= frame_end;
         en_reg         <= bus.en;
         seg_reg        <= blank[slot_reg] ? SEG_XOR : (pat[slot_reg] ^ SEG_XOR);
         dp_reg         <= (shadow_dp_reg[slot_reg] && !blank[slot_reg]) ^ DP_XOR;
         // pcnt==0 marks the first cycle of a slot: keep anodes dark while seg settles.
         an_reg         <= (pcnt_reg == '0 || !en_reg) ? AN_OFF : (an_sel ^ AN_OFF);
      end
   end

   assign bus.seg        = seg_reg;
   assign bus.dp         = dp_reg;
   assign bus.an         = an_reg;
   assign bus.frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_seven_seg_scan4.sv
// Self-checking bench for seven_seg_scan4 (REFRESH_DIV=4, active-low seg and anodes).
module tb_seven_seg_scan4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   seven_seg_scan4_if bus ();

   seven_seg_scan4 #(
      .REFRESH_DIV   (4),
      .SEG_ACTIVE_LOW(1),
      .AN_ACTIVE_LOW (1),
      .BLANK_LEADING (1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       ft;
   } exp_t;

   typedef struct {
      logic [15:0]     digits;
      logic [3:0]      dp_in;
      logic [3:0][6:0] seg;   // expected seg per slot, [k] = slot k
      logic [3:0]      dp;    // expected dp pin per slot
   } vec_t;

   exp_t sb_q[$];
   int   txn = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s txn=%0d got=%h want=%h", name, txn, act, exp);
      end
   endtask

   // One frame as seen right after a frame boundary edge.
   task automatic push_frame(input logic [3:0][6:0] s, input logic [3:0] d);
      exp_t       e;
      logic [3:0] oh;
      for (int k = 0; k < 4; k++) begin
         for (int c = 1; c <= 4; c++) begin
            oh    = 4'b0001 << k;
            e.an  = (c == 1) ? 4'hF : ~oh;
            e.seg = s[k];
            e.dp  = d[k];
            e.ft  = (k == 3 && c == 4);
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic drain(input int n, input int chg_idx, input logic [15:0] chg_dig,
                        input int drop_idx, input int raise_idx);
      exp_t e;
      int   i;
      i = 0;
      while (sb_q.size() > 0 && (n < 0 || i < n)) begin
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         txn++;
         $display("txn %0d: an=%b seg=%h dp=%b ft=%b (want an=%b seg=%h dp=%b ft=%b)",
                  txn, bus.an, bus.seg, bus.dp, bus.frame_tick, e.an, e.seg, e.dp, e.ft);
         check("an", 16'(bus.an), 16'(e.an));
         check("seg", 16'(bus.seg), 16'(e.seg));
         check("dp", 16'(bus.dp), 16'(e.dp));
         check("frame_tick", 16'(bus.frame_tick), 16'(e.ft));
         if (i == chg_idx)   bus.digits = chg_dig;
         if (i == drop_idx)  bus.en = 1'b0;
         if (i == raise_idx) bus.en = 1'b1;
         i++;
      end
   endtask

   vec_t            vecs [6];
   logic [3:0][6:0] prev_seg;
   logic [3:0]      prev_dp;

   initial begin
      vecs[0] = '{16'h0050, 4'b0000, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
      vecs[1] = '{16'h0000, 4'b0100, {7'h7F, 7'h40, 7'h7F, 7'h40}, 4'b1011};
      vecs[2] = '{16'h000A, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h3F}, 4'b1111};
      vecs[3] = '{16'h5678, 4'b1010, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0101};
      vecs[4] = '{16'h0F09, 4'b0000, {7'h7F, 7'h3F, 7'h40, 7'h10}, 4'b1111};
      vecs[5] = '{16'h1111, 4'b0000, {7'h79, 7'h79, 7'h79, 7'h79}, 4'b1111};

      bus.en     = 1'b1;
      bus.digits = 16'h1234;
      bus.dp_in  = 4'b0000;
      rst        = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_an", 16'(bus.an), 16'h000F);
      check("rst_seg", 16'(bus.seg), 16'h007F);
      check("rst_dp", 16'(bus.dp), 16'h0001);
      check("rst_ft", 16'(bus.frame_tick), 16'h0000);
      rst = 1'b0;

      // First frame shows the cleared shadow; tick at cycle 16 loads 1234
      push_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
      drain(-1, -1, 16'h0, -1, -1);
      prev_seg = {7'h79, 7'h24, 7'h30, 7'h19};
      prev_dp  = 4'b1111;

      // Each vector is driven at a frame start and must appear only one frame later
      for (int v = 0; v < 6; v++) begin
         bus.digits = vecs[v].digits;
         bus.dp_in  = vecs[v].dp_in;
         push_frame(prev_seg, prev_dp);
         drain(-1, -1, 16'h0, -1, -1);
         prev_seg = vecs[v].seg;
         prev_dp  = vecs[v].dp;
      end

      // Tear-free: 1111 frame, inputs become 9999 during slot 1
      push_frame(prev_seg, prev_dp);
      drain(-1, 5, 16'h9999, -1, -1);
      bus.digits = 16'h5678;
      bus.dp_in  = 4'b0000;
      push_frame({7'h10, 7'h10, 7'h10, 7'h10}, 4'b1111);
      drain(-1, -1, 16'h0, -1, -1);

      // en dropped in slot 0, raised at slot 1 start; seg keeps scanning
      push_frame({7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111);
      for (int j = 2; j <= 5; j++) sb_q[j].an = 4'hF;
      drain(-1, -1, 16'h0, 0, 4);

      // Reset during slot 2
      bus.digits = 16'h4321;
      push_frame({7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111);
      drain(9, -1, 16'h0, -1, -1);
      sb_q.delete();
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_an", 16'(bus.an), 16'h000F);
      check("midrst_seg", 16'(bus.seg), 16'h007F);
      check("midrst_ft", 16'(bus.frame_tick), 16'h0000);
      rst = 1'b0;
      push_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
      drain(-1, -1, 16'h0, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seven_seg_scan4.md
# seven_seg_scan4

Four-digit multiplexed seven-segment display driver. It sits directly downstream of a cascade of four enabled BCD counter digits, taking their 16-bit packed BCD value and the per-digit decimal points. It time-multiplexes the digits onto one shared segment bus with per-digit anode enables. Digits are latched once per scan frame so counter updates never tear the displayed value. It also provides leading-zero blanking, invalid-code indication and an anti-ghosting dead cycle.

## Interface

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (minimum 4).
- SEG_ACTIVE_LOW, 1: 1 = seg/dp driven low to light; 0 = high to light.
- AN_ACTIVE_LOW, 1: 1 = an driven low to select a digit; 0 = high.
- BLANK_LEADING, 1: 1 = enable leading-zero blanking.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  display enable; 0 forces all anodes inactive.
- digits  in  16  packed BCD; digit k in [4k+3:4k]; digit 0 = least significant, rightmost.
- dp_in  in  4  decimal point per digit; bit k belongs to digit k.
- seg  out  7  segments; seg[0]=a … seg[6]=g; registered.
- dp  out  1  decimal point segment; registered.
- an  out  4  anode selects; an[k] selects digit k; registered.
- frame_tick  out  1  one-cycle pulse when a new frame's digits are latched; registered.

## Operation

- **Prescaler** pcnt runs 0..REFRESH_DIV-1 and wraps. It runs continuously, regardless of en.
- **Slot counter** slot (2 bits):
  - Increments 0→1→2→3→0 on the cycle pcnt == REFRESH_DIV-1.
  - Slot k displays digit k.
- **Shadow register** (16 digits + 4 dp):
  - Loads digits/dp_in on the cycle pcnt == REFRESH_DIV-1 and slot == 3, i.e. the 3→0 transition.
  - Is not updated at any other time.
  - The frame_tick register is set on that same cycle and is high for exactly one cycle after that edge.
- **Decode** (active-high form): 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Codes 10–15 display 0x40 (dash).
- **Leading blanking** (BLANK_LEADING=1):
  - Digit k (k = 3, 2, 1) is blanked when its shadow value is 0, all higher shadow digits are 0, and its shadow dp bit is 0.
  - Digit 0 is never blanked.
  - A blanked digit has seg all off and dp off; its anode is still asserted.
- **Polarity**: when SEG_ACTIVE_LOW = 1, seg and dp are the bitwise inverse of the active-high form. "Off" and "inactive" always mean the unlit/deselected level for the configured polarity.
- **Anti-ghosting**: during the first cycle of every slot, all anodes are inactive.
- **en = 0**: all anodes inactive. seg, dp, slot, pcnt and the shadow register keep operating normally. When en returns to 1, scanning resumes in the current slot.

## Timing

- **Reset** (rst high at an edge) sets: pcnt=0, slot=0, shadow=0, seg off, dp off, an all inactive, frame_tick=0.
  - The first frame after reset displays the shadow value 0: digit 0 shows "0" and digits 3..1 are blanked.
  - The first shadow load happens at the end of that first frame, 4·REFRESH_DIV cycles after reset release.
- **Reset mid-frame** discards the shadow and restarts at slot 0 with pcnt 0 on the next edge.
- **Slot change**: let edge T be the edge at which slot and pcnt wrap.
  - After edge T+1: seg/dp show the new slot's pattern; an is all inactive (dead cycle).
  - After edge T+2: an asserts the new slot's anode, if en = 1.
  - The anode stays asserted until the dead cycle of the next slot.
- **en latency**: en sampled at edge E affects an after edge E+1. There is no effect on seg/dp.
- **Frame timing**: frame period is exactly 4·REFRESH_DIV cycles. frame_tick pulses once per frame.
- **Input changes**: changes to digits/dp_in between loads have no visible effect.
- **Simultaneous shadow load and slot wrap**: slot 0 is decoded from the newly loaded value.

## Test plan

All scenarios use REFRESH_DIV=4, SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1.

- **Reset**: hold rst with digits=16'h1234.
  - During reset: an=4'b1111, seg=7'h7F, dp=1, frame_tick=0.
  - First frame: only an=4'b1110 is lit, with seg=~0x3F=7'h40.
  - frame_tick fires at 16 cycles after release.
  - Next frame shows slots 0..3 as ~0x66, ~0x4F, ~0x5B, ~0x06.
- **Leading zeros**: digits=16'h0050 → digits 3 and 2 have seg=7'h7F; digit 1 = ~0x6D; digit 0 = ~0x3F.
  - digits=16'h0000 with dp_in=4'b0100 → digit 2 shows ~0x3F with dp=0 and is not blanked; digit 3 is blanked.
- **Tear-free**: change digits from 16'h1111 to 16'h9999 during slot 1.
  - Remaining slots of that frame still show ~0x06.
  - ~0x6F appears only after the next frame_tick.
- **Dead cycle and en**:
  - On every slot change, an is 4'b1111 for exactly one cycle before the new anode asserts.
  - Drop en mid-slot → an=4'b1111 one edge later while seg keeps updating.
  - Raise en → the current slot's anode reasserts one edge later.
- **Invalid code**: digits=16'h000A → digit 0 seg = ~0x40 = 7'h3F.
- **Reset mid-frame**: assert rst during slot 2 → next edge gives an inactive, slot 0, shadow cleared; a display of "0" follows.
